// File: rtl/result_stream_writer_pkg.sv
// Shared types and constants for the result stream writer.
// Holds the writer FSM state encoding and the output mode selectors.
package result_stream_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    SCAN,
    DONE
  } state_t;

  localparam int MODE_ALL    = 0;
  localparam int MODE_ARGMAX = 1;

endpackage

// File: rtl/result_stream_writer_argmax.sv
// Sequential signed argmax over one score per cycle.
// best_o already accounts for the score presented this cycle.
module argmax_seq #(
  parameter  int NUM_CLASSES = 10,
  parameter  int DATA_W      = 32,
  localparam int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              first_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] score_i,
  output logic [IDX_W-1:0]  best_o
);

  logic [DATA_W-1:0] best_val_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic              take;

  // Strictly greater replaces, so ties keep the lowest index.
  always_comb begin
    take   = first_i || ($signed(score_i) > $signed(best_val_q));
    best_o = take ? idx_i : best_idx_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else if (valid_i && take) begin
      best_val_q <= score_i;
      best_idx_q <= idx_i;
    end
  end

endmodule

// File: rtl/result_stream_writer.sv
// Streams per-image classifier scores (or their argmax) into a
// byte-addressed result buffer, then signals run completion.
module result_stream_writer
  import result_stream_writer_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int IN_IMG_NUM  = 10,
  parameter int ADDR_STRIDE = 4,
  parameter int MODE        = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CLASSES*DATA_W-1:0] data_in,
  input  logic                          wr_start_i,
  output logic                          busy_o,
  output logic                          y_buf_en,
  output logic                          y_buf_wr_en,
  output logic [ADDR_W-1:0]             y_buf_addr,
  output logic [DATA_W-1:0]             y_buf_data,
  output logic                          done_intr_o,
  output logic                          done_led_o,
  output logic                          ovf_o
);

  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CNT_W = $clog2(IN_IMG_NUM + 1);
  localparam int CAP_W = NUM_CLASSES * DATA_W;

  state_t             state_q, state_d;
  logic [CAP_W-1:0]   cap_q, cap_ld;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   arg_idx;
  logic [CNT_W-1:0]   img_q;
  logic [ADDR_W-1:0]  addr_q, nxt_q;
  logic [DATA_W-1:0]  data_q, wdata_d;
  logic               load, shift, wr_next;
  logic               img_inc, done_set, ovf_set;
  logic               done_intr_q, done_led_q, ovf_q;
  logic               last_idx;

  // In write-all mode class 0 goes straight out, so the rest is pre-shifted.
  assign cap_ld   = (MODE == MODE_ALL) ? (data_in >> DATA_W) : data_in;
  assign last_idx = (idx_q == IDX_W'(NUM_CLASSES - 1));

  if (MODE == MODE_ARGMAX) begin : g_argmax
    argmax_seq #(
      .NUM_CLASSES(NUM_CLASSES),
      .DATA_W     (DATA_W)
    ) u_argmax (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .valid_i(state_q == SCAN),
      .first_i(idx_q == '0),
      .idx_i  (idx_q),
      .score_i(cap_q[DATA_W-1:0]),
      .best_o (arg_idx)
    );
  end else begin : g_all
    assign arg_idx = '0;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = data_q;
    load     = 1'b0;
    shift    = 1'b0;
    wr_next  = 1'b0;
    img_inc  = 1'b0;
    done_set = 1'b0;
    ovf_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_start_i) begin
          load  = 1'b1;
          idx_d = '0;
          if (MODE == MODE_ALL) begin
            state_d = EMIT;
            wr_next = 1'b1;
            wdata_d = data_in[DATA_W-1:0];
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        ovf_set = wr_start_i;
        shift   = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (last_idx) begin
          state_d = EMIT;
          wr_next = 1'b1;
          wdata_d = DATA_W'(arg_idx);
        end
      end
      EMIT: begin
        ovf_set = wr_start_i;
        if (MODE == MODE_ARGMAX || last_idx) begin
          img_inc = 1'b1;
          if (img_q + 1'b1 == CNT_W'(IN_IMG_NUM)) begin
            state_d  = DONE;
            done_set = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          wr_next = 1'b1;
          shift   = 1'b1;
          wdata_d = cap_q[DATA_W-1:0];
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        ovf_set = wr_start_i;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      idx_q       <= '0;
      img_q       <= '0;
      addr_q      <= '0;
      nxt_q       <= '0;
      data_q      <= '0;
      done_intr_q <= 1'b0;
      done_led_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_intr_q <= done_set;
      if (load) cap_q <= cap_ld;
      else if (shift) cap_q <= cap_q >> DATA_W;
      if (wr_next) begin
        data_q <= wdata_d;
        addr_q <= nxt_q;
        nxt_q  <= nxt_q + ADDR_W'(ADDR_STRIDE);
      end
      if (img_inc) img_q <= img_q + 1'b1;
      if (done_set) done_led_q <= 1'b1;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign busy_o      = (state_q == EMIT) || (state_q == SCAN);
  assign y_buf_wr_en = (state_q == EMIT);
  assign y_buf_en    = y_buf_wr_en;
  assign y_buf_addr  = addr_q;
  assign y_buf_data  = data_q;
  assign done_intr_o = done_intr_q;
  assign done_led_o  = done_led_q;
  assign ovf_o       = ovf_q;

endmodule
